// File: rtl/shift_pkg.sv
// Shared constants and elaboration helpers for the shifter datapath.
package shift_pkg;

    localparam logic [1:0] SHL = 2'b00;
    localparam logic [1:0] SHR = 2'b01;
    localparam logic [1:0] SRA = 2'b10;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Shifter core latency from v_in to v_out for a given data width.
    function automatic int unsigned SHIFT_LAT(input int unsigned width);
        return clog2(width) + 2;
    endfunction

endpackage

// File: rtl/shift_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is read combinationally.
module shift_sync_fifo
    import shift_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [W-1:0]          wr_data,
    input  logic                  rd_en,
    output logic [W-1:0]          rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [clog2(DEPTH):0] count
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_wr;
    logic         do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    // Storage and pointer update; write and read may both happen in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/shift_result_buffer.sv
// Credit-gated issue and in-order result buffering for the fixed-latency shifter core.
module shift_result_buffer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned LAT   = SHIFT_LAT(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [TAG_W-1:0]      iss_tag,
    output logic                  iss_ready,
    output logic                  core_v_in,
    input  logic                  core_v_out,
    input  logic [WIDTH-1:0]      core_dout,
    output logic                  res_valid,
    output logic [WIDTH-1:0]      res_data,
    output logic [TAG_W-1:0]      res_tag,
    input  logic                  res_ready,
    output logic [clog2(DEPTH):0] occupancy,
    output logic                  err
);

    localparam int unsigned CW = clog2(DEPTH) + 1;
    localparam int unsigned FW = clog2(LAT + 1);

    typedef enum logic {
        S_FLUSH = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [FW-1:0] flush_cnt;
    logic [FW-1:0] flush_nxt;
    logic [CW-1:0] credits;
    logic [CW-1:0] credits_nxt;
    logic          err_nxt;
    logic          iss_ready_nxt;

    logic          fire;
    logic          pop;
    logic          core_seen;
    logic          core_bad;
    logic          data_wr;
    logic          data_empty;
    logic          data_full;
    logic          tag_empty;
    logic          tag_full;
    logic [CW-1:0] tag_count;
    logic          unused_tag_count;

    assign fire      = iss_valid && iss_ready;
    assign pop       = res_valid && res_ready;
    assign core_v_in = fire;

    // Core results only count once stale pipeline contents have been flushed.
    assign core_seen = (state == S_RUN) && core_v_out;
    assign core_bad  = core_seen && (data_full || tag_empty);
    assign data_wr   = core_seen && !data_full && !tag_empty;

    assign res_valid        = !data_empty;
    assign unused_tag_count = ^tag_count;

    shift_sync_fifo #(
        .W     (WIDTH),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (data_wr),
        .wr_data (core_dout),
        .rd_en   (pop),
        .rd_data (res_data),
        .empty   (data_empty),
        .full    (data_full),
        .count   (occupancy)
    );

    shift_sync_fifo #(
        .W     (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fire && !tag_full),
        .wr_data (iss_tag),
        .rd_en   (pop && !tag_empty),
        .rd_data (res_tag),
        .empty   (tag_empty),
        .full    (tag_full),
        .count   (tag_count)
    );

    // State, flush counter, credits, sticky error and registered issue-ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FLUSH;
            flush_cnt <= FW'(LAT);
            credits   <= CW'(DEPTH);
            err       <= 1'b0;
            iss_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_nxt;
            credits   <= credits_nxt;
            err       <= err_nxt;
            iss_ready <= iss_ready_nxt;
        end
    end

    // Next-state: count down the flush window, then track credits and protocol errors.
    always_comb begin
        state_nxt   = state;
        flush_nxt   = flush_cnt;
        credits_nxt = credits;
        err_nxt     = err;

        case (state)
            S_FLUSH: begin
                if (flush_cnt != '0) begin
                    flush_nxt = flush_cnt - FW'(1);
                end
                if (flush_cnt <= FW'(1)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (fire && !pop) begin
                    credits_nxt = credits - CW'(1);
                end else if (pop && !fire && (credits != CW'(DEPTH))) begin
                    credits_nxt = credits + CW'(1);
                end
                if (core_bad) begin
                    err_nxt = 1'b1;
                end
            end
        endcase

        iss_ready_nxt = (state_nxt == S_RUN) && (credits_nxt != '0);
    end

endmodule
